// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and GF(2^8) helpers for the
// inverse-cipher datapath.
package aes_pkg;

  // [col][row]; byte n of the block sits at [3-n/4][3-n%4]
  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    ADDKEY,
    ROUND
  } fsm_e;

  localparam logic [7:0] RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // multiply by x modulo 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
// state_in/round_key -> InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns (bypassed when last_round) -> state_out.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  state_t s_in;
  state_t sr;
  state_t sb;
  state_t ak;
  state_t mc;

  assign s_in = state_in;

  // logical (col c, row r) lives at physical [3-c][3-r]
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SC = (c + 4 - r) % 4;
      assign sr[3-c][3-r] = s_in[3-SC][3-r];
      assign sb[3-c][3-r] = inv_sbox(sr[3-c][3-r]);
    end
  end

  assign ak = sb ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    localparam int PC = 3 - c;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ak[PC][3];
    assign a1 = ak[PC][2];
    assign a2 = ak[PC][1];
    assign a3 = ak[PC][0];
    assign mc[PC][3] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                     ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mc[PC][2] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                     ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mc[PC][1] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                     ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mc[PC][0] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                     ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  assign state_out = last_round ? ak : mc;

endmodule

// File: rtl/main_decrypt.sv
// Iterative AES-128 decryption: 10-cycle key expansion, then
// 11 inverse-round cycles. Ports: clk, rst, start, encr_data,
// key -> decryp_data, busy, valid (one-cycle completion pulse).
module main_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] encr_data,
  input  logic [0:127] key,
  output logic [0:127] decryp_data,
  output logic         busy,
  output logic         valid
);

  fsm_e         state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         fin_q, fin_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];

  logic [127:0] prev_rk;
  logic [31:0]  tmp_w;
  logic [127:0] next_rk;
  logic [127:0] rnd_out;

  // one key-schedule step: rk[cnt] from rk[cnt-1]
  always_comb begin
    prev_rk = rk_q[cnt_q - 4'd1];
    tmp_w = sub_word({prev_rk[23:0], prev_rk[31:24]})
          ^ {RCON[cnt_q], 24'h0};
    next_rk[127:96] = prev_rk[127:96] ^ tmp_w;
    next_rk[95:64]  = prev_rk[95:64] ^ next_rk[127:96];
    next_rk[63:32]  = prev_rk[63:32] ^ next_rk[95:64];
    next_rk[31:0]   = prev_rk[31:0] ^ next_rk[63:32];
  end

  aes_inv_round u_round (
    .state_in   (st_q),
    .round_key  (rk_q[cnt_q]),
    .last_round (cnt_q == 4'd0),
    .state_out  (rnd_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    out_d   = out_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    fin_d   = fin_q;
    rk_d    = rk_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = encr_data;
          rk_d[0] = key;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[cnt_q] = next_rk;
        if (cnt_q == 4'd10) state_d = ADDKEY;
        else cnt_d = cnt_q + 4'd1;
      end
      ADDKEY: begin
        st_d    = st_q ^ rk_q[10];
        cnt_d   = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        // after round 0: one cycle to publish, one with valid
        // high before IDLE can accept a new start
        if (valid_q) begin
          state_d = IDLE;
        end else if (fin_q) begin
          out_d   = st_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          fin_d   = 1'b0;
        end else begin
          st_d = rnd_out;
          if (cnt_q == 4'd0) fin_d = 1'b1;
          else cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      rk_q    <= rk_d;
    end
  end

  assign decryp_data = out_q;
  assign busy        = busy_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_main_decrypt.sv
// Directed bench for main_decrypt: FIPS-197 vectors, busy
// protocol, back-to-back, reset behaviour.
module tb_main_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] encr_data;
  logic [127:0] key;
  logic [127:0] decryp_data;
  logic         busy;
  logic         valid;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ZERO = 128'h0;

  main_decrypt dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .encr_data   (encr_data),
    .key         (key),
    .decryp_data (decryp_data),
    .busy        (busy),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM idle. Start is sampled at
  // the next posedge (edge E); valid must appear after E+22.
  task automatic run_op(
    input string        tag,
    input logic [127:0] k,
    input logic [127:0] c,
    input logic [127:0] p,
    input logic [127:0] prev,
    input bit           noisy
  );
    int pulses;
    pulses    = 0;
    start     = 1'b1;
    key       = k;
    encr_data = c;
    @(posedge clk);
    for (int i = 0; i <= 22; i++) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
      chk({tag, " busy"}, 128'(busy), 128'(i < 22));
      chk({tag, " valid"}, 128'(valid), 128'(i == 22));
      chk({tag, " data"}, decryp_data, (i == 22) ? p : prev);
      if (noisy) begin
        start     = 1'b1;
        key       = {$urandom, $urandom, $urandom, $urandom};
        encr_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    if (valid === 1'b1) pulses++;
    chk({tag, " pulses"}, 128'(pulses), 128'(1));
    chk({tag, " idle busy"}, 128'(busy), 128'(0));
    chk({tag, " hold data"}, decryp_data, p);
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    key       = K_C1;
    encr_data = C_C1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst data", decryp_data, ZERO);
      chk("rst busy", 128'(busy), 128'(0));
      chk("rst valid", 128'(valid), 128'(0));
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_op("c1", K_C1, C_C1, P_C1, ZERO, 1'b0);
    run_op("zero", ZERO, C_Z, ZERO, P_C1, 1'b0);
    run_op("c1 noisy", K_C1, C_C1, P_C1, ZERO, 1'b1);
    run_op("appb", K_B, C_B, P_B, P_C1, 1'b0);

    start     = 1'b1;
    key       = K_C1;
    encr_data = C_C1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort data", decryp_data, ZERO);
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort valid", 128'(valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post abort", {valid, busy, decryp_data[125:0]},
          {2'b00, 126'h0});
    end

    run_op("appb after rst", K_B, C_B, P_B, ZERO, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
